// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- two-stage pipelined immediate generator for LEGv8-style
// instruction words.
//
// Stage 1 captures the instruction and its decoded immediate format; stage 2
// captures the extended immediate that is presented on the outputs.
//
// Parameters
//   DATA_W   : immediate width (32 or 64)
//   BR_SHIFT : 1 = B/CB offsets are shifted left by 2 after extension
//   ERR_W    : width of the saturating illegal-instruction counter
//
// Ports
//   CLK      in   clock, all state updates on the rising edge
//   Reset    in   asynchronous active-high reset
//   InValid  in   Imm32 carries an instruction this cycle
//   InReady  out  block accepts Imm32 this cycle
//   Imm32    in   instruction word
//   OutValid out  BusImm/ImmType/Illegal are valid
//   OutReady in   consumer accepts the output this cycle
//   BusImm   out  extended immediate (DATA_W bits)
//   ImmType  out  0=B 1=CB 2=D 3=I 4=IW 7=illegal
//   Illegal  out  instruction matched no format
//   ErrCnt   out  saturating count of illegal instructions delivered
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer may raise valid without waiting for ready and must
// hold its data until the transfer; ready may depend combinationally on the
// downstream ready (InReady follows OutReady) but valid never depends on
// ready. While OutValid=1 and OutReady=0 the output payload is held stable.

module imm_gen_pipe #(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 0,
  parameter int ERR_W    = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Imm32,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] BusImm,
  output logic [2:0]        ImmType,
  output logic              Illegal,
  output logic [ERR_W-1:0]  ErrCnt
);

  typedef enum logic [2:0] {
    IMM_B   = 3'd0,
    IMM_CB  = 3'd1,
    IMM_D   = 3'd2,
    IMM_I   = 3'd3,
    IMM_IW  = 3'd4,
    IMM_ILL = 3'd7
  } imm_type_e;

  localparam bit BR_EN  = (BR_SHIFT != 0);
  localparam bit NARROW = (DATA_W == 32);

  // Stage 1 state. Only Imm32[25:0] is kept: the opcode bits above are
  // fully summarised by the decoded type.
  logic        s1_valid;
  logic [25:0] s1_inst;
  imm_type_e   s1_type;

  // Stage 2 state drives the outputs directly.
  logic        s2_valid;

  // Holds InReady low until the first clock edge after reset is released.
  logic        ready_en;

  imm_type_e         dec_type;
  logic              is_d;
  logic [DATA_W-1:0] ext;

  logic s2_can_load;
  logic s1_advance;
  logic in_xfer;
  logic out_xfer;

  // ---------------------------------------------------------------------
  // Format decode (priority order B, CB, D, I, IW)
  // ---------------------------------------------------------------------
  always_comb begin
    is_d = 1'b0;
    case (Imm32[31:21])
      11'b00111000000,  // STURB
      11'b00111000010,  // LDURB
      11'b01111000000,  // STURH
      11'b01111000010,  // LDURH
      11'b10111000000,  // STURW
      11'b10111000100,  // LDURSW
      11'b11001000000,  // STXR
      11'b11001000010,  // LDXR
      11'b11111000000,  // STURD
      11'b11111000010:  // LDURD
        is_d = 1'b1;
      default: is_d = 1'b0;
    endcase
  end

  always_comb begin
    dec_type = IMM_ILL;
    if (Imm32[31:26] == 6'b000101 || Imm32[31:26] == 6'b100101) begin
      dec_type = IMM_B;
    end else if (Imm32[31:24] == 8'b01010100 || Imm32[31:24] == 8'b10110100 ||
                 Imm32[31:24] == 8'b10110101) begin
      dec_type = IMM_CB;
    end else if (is_d) begin
      dec_type = IMM_D;
    end else if (Imm32[31:22] == 10'b1001000100 || Imm32[31:22] == 10'b1101000100) begin
      dec_type = IMM_I;
    end else if (Imm32[31:23] == 9'b110100101) begin
      // A 32-bit immediate cannot hold a MOVZ with hw = 2 or 3.
      if (NARROW && Imm32[22]) dec_type = IMM_ILL;
      else                     dec_type = IMM_IW;
    end
  end

  // ---------------------------------------------------------------------
  // Extension from stage 1 contents
  // ---------------------------------------------------------------------
  always_comb begin
    ext = '0;
    case (s1_type)
      IMM_B: begin
        ext = {{(DATA_W-26){s1_inst[25]}}, s1_inst[25:0]};
        if (BR_EN) ext = ext << 2;
      end
      IMM_CB: begin
        ext = {{(DATA_W-19){s1_inst[23]}}, s1_inst[23:5]};
        if (BR_EN) ext = ext << 2;
      end
      IMM_D:  ext = {{(DATA_W-9){s1_inst[20]}}, s1_inst[20:12]};
      IMM_I:  ext = {{(DATA_W-12){1'b0}}, s1_inst[21:10]};
      // hw field selects a shift of 0/16/32/48.
      IMM_IW: ext = {{(DATA_W-16){1'b0}}, s1_inst[20:5]} << {s1_inst[22:21], 4'b0000};
      default: ext = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------
  assign out_xfer    = s2_valid & OutReady;
  // Stage 2 takes new content when empty (bubble collapse) or draining now.
  assign s2_can_load = !s2_valid | OutReady;
  assign s1_advance  = s1_valid & s2_can_load;
  assign InReady     = ready_en & (!s1_valid | s2_can_load);
  assign in_xfer     = InValid & InReady;
  assign OutValid    = s2_valid;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
      s1_type  <= IMM_B;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_inst  <= Imm32[25:0];
        s1_type  <= dec_type;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s2_valid <= 1'b0;
      BusImm   <= '0;
      ImmType  <= 3'd0;
      Illegal  <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        BusImm  <= ext;
        ImmType <= s1_type;
        Illegal <= (s1_type == IMM_ILL);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ErrCnt <= '0;
    end else if (out_xfer && Illegal && (ErrCnt != {ERR_W{1'b1}})) begin
      ErrCnt <= ErrCnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe. Two instances share the input stream and the
// output handshake: dut_a uses the defaults (DATA_W=64, BR_SHIFT=0) and
// dut_b uses DATA_W=32, BR_SHIFT=1. Each has its own expected queue.

module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] imm32;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [63:0] bus_a;
  logic [2:0]  type_a;
  logic [7:0]  errcnt_a;

  logic        in_ready_b, out_valid_b, illegal_b;
  logic [31:0] bus_b;
  logic [2:0]  type_b;
  logic [7:0]  errcnt_b;

  imm_gen_pipe dut_a (
    .CLK(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready_a), .Imm32(imm32),
    .OutValid(out_valid_a), .OutReady(out_ready), .BusImm(bus_a), .ImmType(type_a),
    .Illegal(illegal_a), .ErrCnt(errcnt_a)
  );

  imm_gen_pipe #(.DATA_W(32), .BR_SHIFT(1), .ERR_W(8)) dut_b (
    .CLK(clk), .Reset(rst), .InValid(in_valid), .InReady(in_ready_b), .Imm32(imm32),
    .OutValid(out_valid_b), .OutReady(out_ready), .BusImm(bus_b), .ImmType(type_b),
    .Illegal(illegal_b), .ErrCnt(errcnt_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [67:0] exp_q_a[$];   // {imm[63:0], type[2:0], illegal}
  logic [35:0] exp_q_b[$];   // {imm[31:0], type[2:0], illegal}
  int          t_q[$];
  logic [67:0] cur_a;
  logic [35:0] cur_b;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          pops_a;
  int          exp_err_a, exp_err_b;
  bit          chk_lat;
  bit          last_acc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model built from the format table.
  function automatic logic [67:0] model(input logic [31:0] ins, input bit narrow, input bit brs);
    logic [63:0] v;
    logic [2:0]  t;
    logic [10:0] op11;
    v = '0;
    t = 3'd7;
    op11 = ins[31:21];
    if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      t = 3'd0;
      v = {{38{ins[25]}}, ins[25:0]};
      if (brs) v = v << 2;
    end else if (ins[31:24] == 8'h54 || ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5) begin
      t = 3'd1;
      v = {{45{ins[23]}}, ins[23:5]};
      if (brs) v = v << 2;
    end else if (op11 inside {11'h1C0, 11'h1C2, 11'h3C0, 11'h3C2, 11'h5C0,
                              11'h5C4, 11'h640, 11'h642, 11'h7C0, 11'h7C2}) begin
      t = 3'd2;
      v = {{55{ins[20]}}, ins[20:12]};
    end else if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1101000100) begin
      t = 3'd3;
      v = {52'd0, ins[21:10]};
    end else if (ins[31:23] == 9'b110100101 && !(narrow && ins[22])) begin
      t = 3'd4;
      case (ins[22:21])
        2'd0: v = {48'd0, ins[20:5]};
        2'd1: v = {32'd0, ins[20:5], 16'd0};
        2'd2: v = {16'd0, ins[20:5], 32'd0};
        default: v = {ins[20:5], 48'd0};
      endcase
    end
    if (t == 3'd7) v = '0;
    if (narrow) v = {32'd0, v[31:0]};
    return {v, t, (t == 3'd7)};
  endfunction

  function automatic logic [35:0] model_b(input logic [31:0] ins);
    logic [67:0] r;
    r = model(ins, 1'b1, 1'b1);
    return r[35:0];
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [10:0] op;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w = {($urandom_range(0, 1) != 0) ? 6'b100101 : 6'b000101, w[25:0]};
      1: begin
        case ($urandom_range(0, 2))
          0: w = {8'h54, w[23:0]};
          1: w = {8'hB4, w[23:0]};
          default: w = {8'hB5, w[23:0]};
        endcase
      end
      2: begin
        case ($urandom_range(0, 9))
          0: op = 11'h1C0;  1: op = 11'h1C2;  2: op = 11'h3C0;  3: op = 11'h3C2;
          4: op = 11'h5C0;  5: op = 11'h5C4;  6: op = 11'h640;  7: op = 11'h642;
          8: op = 11'h7C0;  default: op = 11'h7C2;
        endcase
        w = {op, w[20:0]};
      end
      3: w = {($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100, w[21:0]};
      4: w = {9'b110100101, w[22:0]};
      default: ;
    endcase
    return w;
  endfunction

  // Checks outputs against the queue heads at the negedge, then records the
  // transfers that will happen at the following posedge.
  task automatic monitor();
    check("errcnt_a", 64'(errcnt_a), 64'(exp_err_a));
    check("errcnt_b", 64'(errcnt_b), 64'(exp_err_b));
    if (exp_q_a.size() == 0) begin
      check("idle_a", 64'(out_valid_a), 64'd0);
    end else if (out_valid_a) begin
      check("bus_a", bus_a, exp_q_a[0][67:4]);
      check("type_a", 64'(type_a), 64'(exp_q_a[0][3:1]));
      check("illegal_a", 64'(illegal_a), 64'(exp_q_a[0][0]));
      if (out_ready) begin
        if (chk_lat) check("latency", 64'(cyc - t_q[0]), 64'd2);
        if (exp_q_a[0][0] && exp_err_a < 255) exp_err_a++;
        void'(exp_q_a.pop_front());
        void'(t_q.pop_front());
        pops_a++;
      end
    end
    if (exp_q_b.size() == 0) begin
      check("idle_b", 64'(out_valid_b), 64'd0);
    end else if (out_valid_b) begin
      check("bus_b", 64'(bus_b), 64'(exp_q_b[0][35:4]));
      check("type_b", 64'(type_b), 64'(exp_q_b[0][3:1]));
      check("illegal_b", 64'(illegal_b), 64'(exp_q_b[0][0]));
      if (out_ready) begin
        if (exp_q_b[0][0] && exp_err_b < 255) exp_err_b++;
        void'(exp_q_b.pop_front());
      end
    end
    last_acc = in_valid && in_ready_a;
    if (in_valid && in_ready_a) begin
      exp_q_a.push_back(cur_a);
      t_q.push_back(cyc);
    end
    if (in_valid && in_ready_b) exp_q_b.push_back(cur_b);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] ins, input logic [67:0] ea, input logic [35:0] eb);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    imm32 = ins;
    cur_a = ea;
    cur_b = eb;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      done = last_acc;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] ins);
    send(ins, model(ins, 1'b0, 1'b0), model_b(ins));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); i++) step();
    check("drain_a", 64'(exp_q_a.size()), 64'd0);
    check("drain_b", 64'(exp_q_b.size()), 64'd0);
  endtask

  function automatic logic [67:0] pk_a(input logic [63:0] v, input logic [2:0] t);
    return {v, t, (t == 3'd7)};
  endfunction

  function automatic logic [35:0] pk_b(input logic [31:0] v, input logic [2:0] t);
    return {v, t, (t == 3'd7)};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    logic [31:0] w;
    rst = 1'b1;
    in_valid = 1'b0;
    imm32 = '0;
    out_ready = 1'b1;
    cur_a = '0;
    cur_b = '0;
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    pops_a = 0;
    exp_err_a = 0;
    exp_err_b = 0;
    chk_lat = 1'b0;
    last_acc = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_bus", bus_a, 64'd0);
    check("rst_type", 64'(type_a), 64'd0);
    check("rst_illegal", 64'(illegal_a), 64'd0);
    check("rst_errcnt", 64'(errcnt_a), 64'd0);
    check("rst_in_ready_a", 64'(in_ready_a), 64'd0);
    check("rst_in_ready_b", 64'(in_ready_b), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(in_ready_a), 64'd1);

    // Directed vectors, back-to-back with OutReady=1
    chk_lat = 1'b1;
    send(32'h17FFFFFF, pk_a(64'hFFFFFFFFFFFFFFFF, 3'd0), pk_b(32'hFFFFFFFC, 3'd0));
    send(32'hF8500000, pk_a(64'hFFFFFFFFFFFFFF00, 3'd2), pk_b(32'hFFFFFF00, 3'd2));
    send(32'h913FFC00, pk_a(64'h0000000000000FFF, 3'd3), pk_b(32'h00000FFF, 3'd3));
    send(32'hD2B579A0, pk_a(64'h00000000ABCD0000, 3'd4), pk_b(32'hABCD0000, 3'd4));
    send(32'hD2D579A0, pk_a(64'h0000ABCD00000000, 3'd4), pk_b(32'h0, 3'd7));
    send(32'hD2E00020, pk_a(64'h0001000000000000, 3'd4), pk_b(32'h0, 3'd7));
    send(32'h54FFFFE0, pk_a(64'hFFFFFFFFFFFFFFFF, 3'd1), pk_b(32'hFFFFFFFC, 3'd1));
    send(32'hB4000020, pk_a(64'h0000000000000001, 3'd1), pk_b(32'h00000004, 3'd1));
    send(32'h94000010, pk_a(64'h0000000000000010, 3'd0), pk_b(32'h00000040, 3'd0));
    send(32'hD1000400, pk_a(64'h0000000000000001, 3'd3), pk_b(32'h00000001, 3'd3));
    send(32'h380FF000, pk_a(64'h00000000000000FF, 3'd2), pk_b(32'h000000FF, 3'd2));
    send(32'hB89FF000, pk_a(64'hFFFFFFFFFFFFFFFF, 3'd2), pk_b(32'hFFFFFFFF, 3'd2));
    send(32'hC8000000, pk_a(64'h0, 3'd2), pk_b(32'h0, 3'd2));
    send(32'h00000000, pk_a(64'h0, 3'd7), pk_b(32'h0, 3'd7));
    drain();
    chk_lat = 1'b0;

    // Stall: three back-to-back inputs with OutReady=0
    out_ready = 1'b0;
    in_valid = 1'b1;
    imm32 = 32'hF8500000; cur_a = model(imm32, 1'b0, 1'b0); cur_b = model_b(imm32);
    step();
    check("stall_acc1", 64'(last_acc), 64'd1);
    imm32 = 32'h913FFC00; cur_a = model(imm32, 1'b0, 1'b0); cur_b = model_b(imm32);
    step();
    check("stall_acc2", 64'(last_acc), 64'd1);
    imm32 = 32'hD2B579A0; cur_a = model(imm32, 1'b0, 1'b0); cur_b = model_b(imm32);
    check("stall_ready", 64'(in_ready_a), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_acc", 64'(last_acc), 64'd0);
    end
    out_ready = 1'b1;
    n0 = pops_a;
    step();
    check("stall_acc3", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    step();
    step();
    check("stall_drain_pops", 64'(pops_a - n0), 64'd3);
    drain();

    // Random traffic with random stalls
    w = rand_inst();
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || last_acc) begin
        w = rand_inst();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      imm32 = w;
      cur_a = model(w, 1'b0, 1'b0);
      cur_b = model_b(w);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(32'h00000000, pk_a(64'h0, 3'd7), pk_b(32'h0, 3'd7));
    drain();
    check("errcnt_sat_a", 64'(errcnt_a), 64'd255);
    check("errcnt_sat_b", 64'(errcnt_b), 64'd255);

    // Reset with both stages full
    out_ready = 1'b0;
    send_m(32'h17FFFFFF);
    send_m(32'h913FFC00);
    check("full_out_valid", 64'(out_valid_a), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid_a", 64'(out_valid_a), 64'd0);
    check("midrst_out_valid_b", 64'(out_valid_b), 64'd0);
    check("midrst_errcnt_a", 64'(errcnt_a), 64'd0);
    check("midrst_bus_a", bus_a, 64'd0);
    check("midrst_in_ready", 64'(in_ready_a), 64'd0);
    exp_q_a.delete();
    exp_q_b.delete();
    t_q.delete();
    exp_err_a = 0;
    exp_err_b = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("post_rst_ready", 64'(in_ready_a), 64'd1);
    send_m(32'hB4000020);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DATA_W, default 64, immediate output width; legal values 32 and 64.
REQ-002 Parameter BR_SHIFT, default 0; 1 = B/CB offsets shifted left by 2 after extension.
REQ-003 Parameter ERR_W, default 8, width of the illegal-instruction counter.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 InValid  input  1  Imm32 carries an instruction this cycle.
REQ-007 InReady  output  1  block accepts Imm32 this cycle.
REQ-008 Imm32  input  32  instruction word.
REQ-009 OutValid  output  1  BusImm/ImmType/Illegal are valid.
REQ-010 OutReady  input  1  consumer accepts the output this cycle.
REQ-011 BusImm  output  DATA_W  extended immediate.
REQ-012 ImmType  output  3  0=B, 1=CB, 2=D, 3=I, 4=IW, 7=illegal.
REQ-013 Illegal  output  1  instruction matched no format.
REQ-014 ErrCnt  output  ERR_W  saturating count of illegal instructions delivered.

Function
REQ-015 Decode priority: B (Imm32[31:26] = 000101 or 100101); CB (Imm32[31:24] = 01010100, 10110100, 10110101); D (Imm32[31:21] in {STURB, LDURB, STURH, LDURH, STURW, LDURSW, STXR, LDXR, STURD, LDURD}); I (Imm32[31:22] = 1001000100 ADDI or 1101000100 SUBI); IW (Imm32[31:23] = 110100101 MOVZ); otherwise illegal.
REQ-016 B: Imm32[25:0] sign-extended to DATA_W; CB: Imm32[23:5] sign-extended; D: Imm32[20:12] sign-extended.
REQ-017 When BR_SHIFT=1, B and CB results are shifted left 2 after extension (bits above DATA_W discarded); D is never shifted.
REQ-018 I: Imm32[21:10] zero-extended.
REQ-019 IW: Imm32[20:5] zero-extended, then shifted left 16*Imm32[22:21].
REQ-020 IW with DATA_W=32 and Imm32[22]=1 is illegal.
REQ-021 Illegal: BusImm=0, ImmType=7, Illegal=1.
REQ-022 Two-stage pipeline:
- Stage 1 registers Imm32 plus the decoded type.
- Stage 2 registers the extended result.
- Latency is exactly 2 cycles from accept to OutValid with no stall.
- Throughput is 1 per cycle.
REQ-023 Transfer rules:
- Input transfer occurs when InValid & InReady.
- Output transfer occurs when OutValid & OutReady.
- InValid is not required to wait for InReady.
REQ-024 Stage 2 loads when empty or its content transfers this cycle; stage 1 loads when empty or advancing into stage 2.
REQ-025 InReady = !S1Valid | S2CanLoad; combinational from OutReady; no other combinational input-to-output path.
REQ-026 While OutValid=1 and OutReady=0, BusImm, ImmType and Illegal are held stable.
REQ-027 Two instructions are buffered under stall; InReady=0 while both stages are full and OutReady=0.
REQ-028 Bubbles collapse: an empty stage 2 loads from stage 1 regardless of OutReady.
REQ-029 ErrCnt increments by 1 on each output transfer with Illegal=1 and saturates at 2^ERR_W-1.
REQ-030 A simultaneous input transfer and output transfer on a full pipe shifts both stages with no data loss.

Reset
REQ-031 Reset=1 asynchronously clears both stage valids.
REQ-032 Reset=1 forces OutValid=0, BusImm=0, ImmType=0, Illegal=0 and ErrCnt=0.
REQ-033 Reset=1 forces InReady=0.
REQ-034 In-flight instructions are discarded on reset.
REQ-035 InReady=1 from the first clock edge after Reset falls.

Verification
REQ-036 DATA_W=64, BR_SHIFT=0; Imm32=0x17FFFFFF, OutReady=1 -> 2 cycles later BusImm=0xFFFFFFFFFFFFFFFF, ImmType=0; with BR_SHIFT=1 -> 0xFFFFFFFFFFFFFFFC.
REQ-037 LDURD with imm9=0x100 (Imm32=0xF8500000) -> BusImm=0xFFFFFFFFFFFFFF00, ImmType=2; ADDI imm12=0xFFF (Imm32=0x913FFC00) -> 0x0000000000000FFF, ImmType=3.
REQ-038 MOVZ hw=1, imm16=0xABCD (Imm32=0xD2B579A0) -> BusImm=0x00000000ABCD0000, ImmType=4; with DATA_W=32 and hw=2 -> Illegal=1.
REQ-039 Stall sequence:
- Stimulus: three back-to-back inputs with OutReady=0.
- Response: InReady falls after two accepts, outputs are held, and releasing OutReady drains all three in order on consecutive cycles.
REQ-040 Error counting:
- Stimulus: 300 Imm32=0x00000000 with ERR_W=8.
- Response: each output shows Illegal=1 and BusImm=0, and ErrCnt ends at 255.
REQ-041 Reset mid-operation:
- Stimulus: assert Reset mid-cycle with both stages full.
- Response: OutValid=0 and ErrCnt=0 immediately, with no output after release until a new input is accepted.
